conv3x3_stream_ctrl: RTL and testbench



---
 rtl/conv3x3_stream_ctrl.sv | 179 +++++++++++++++++
 tb/tb_conv3x3_stream_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream_ctrl.sv
// conv3x3_stream_ctrl
// Sequencing controller for a bank of 3x3 convolution channel engines. It
// accepts one raster-ordered IMG_SIZE x IMG_SIZE frame and drives the shared
// line-buffer shift strobe. It reports each completed 3x3 window with its
// centre coordinate and a "same"-padding tap mask. At end of frame it issues
// IMG_SIZE+1 flush strobes so the last row of windows drains, then pulses
// frame_done.
//
// Ports:
//   Clk, Rst      clock, synchronous active-high reset
//   start         begin a frame (honoured only while idle)
//   valid_in      upstream pixel valid
//   in_ready      pixel accepted this cycle when valid_in is also high
//   shift_en      line-buffer shift strobe (accept or flush)
//   window_valid  registered; window at (out_row, out_col) is complete
//   out_row/col   registered window centre, held while window_valid=0
//   pad_mask      registered tap mask, bit k set = tap wk outside the image
//   busy          high in any state other than idle
//   frame_done    one-cycle end-of-frame pulse
//   ds_row/col    (optional) downsampled centre, orow>>1 / ocol>>1
//
// Optional feature macro CONV3X3_STREAM_CTRL_STRIDE2_EN: emit only windows
// whose centre row and column are both even, and add the ds_row/ds_col ports.

module conv3x3_stream_ctrl #(
   parameter int unsigned IMG_SIZE = 104,
   parameter int unsigned CNT_W    = $clog2(IMG_SIZE)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             start,
   input  logic             valid_in,
   output logic             in_ready,
   output logic             shift_en,
   output logic             window_valid,
   output logic [CNT_W-1:0] out_row,
   output logic [CNT_W-1:0] out_col,
   output logic [8:0]       pad_mask,
   output logic             busy,
   output logic             frame_done
`ifdef CONV3X3_STREAM_CTRL_STRIDE2_EN
   ,
   output logic [CNT_W-2:0] ds_row,
   output logic [CNT_W-2:0] ds_col
`endif
);

   localparam int unsigned StrobeTotal = IMG_SIZE * IMG_SIZE + IMG_SIZE + 1;
   localparam int unsigned StrobeW     = $clog2(StrobeTotal + 1);
   localparam int unsigned FlushW      = CNT_W + 1;

   localparam logic [StrobeW-1:0] StrobeMax = StrobeW'(StrobeTotal);
   // Strobes before this count only prime the line buffer.
   localparam logic [StrobeW-1:0] WinStart  = StrobeW'(IMG_SIZE + 1);
   localparam logic [CNT_W-1:0]   LastIdx   = CNT_W'(IMG_SIZE - 1);
   localparam logic [FlushW-1:0]  FlushLast = FlushW'(IMG_SIZE);

   typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

   state_e               state_q;
   logic [CNT_W-1:0]     irow_q, icol_q;
   logic [CNT_W-1:0]     orow_q, ocol_q;
   logic [FlushW-1:0]    flush_q;
   logic [StrobeW-1:0]   strobe_q;

   logic                 accept;
   logic                 flush_stb;
   logic                 win_stb;
   logic                 emit;
   logic                 last_px;
   logic [8:0]           win_mask;

   always_comb begin
      in_ready  = (state_q == StRun);
      accept    = valid_in & in_ready;
      flush_stb = (state_q == StFlush);
      shift_en  = accept | flush_stb;
      win_stb   = shift_en & (strobe_q >= WinStart);
      last_px   = accept & (irow_q == LastIdx) & (icol_q == LastIdx);

      win_mask = '0;
      if (orow_q == '0)     win_mask = win_mask | 9'b000_000_111;
      if (orow_q == LastIdx) win_mask = win_mask | 9'b111_000_000;
      if (ocol_q == '0)     win_mask = win_mask | 9'b001_001_001;
      if (ocol_q == LastIdx) win_mask = win_mask | 9'b100_100_100;

`ifdef CONV3X3_STREAM_CTRL_STRIDE2_EN
      emit = win_stb & ~orow_q[0] & ~ocol_q[0];
`else
      emit = win_stb;
`endif
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q      <= StIdle;
         irow_q       <= '0;
         icol_q       <= '0;
         orow_q       <= '0;
         ocol_q       <= '0;
         flush_q      <= '0;
         strobe_q     <= '0;
         window_valid <= 1'b0;
         out_row      <= '0;
         out_col      <= '0;
         pad_mask     <= '0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
`ifdef CONV3X3_STREAM_CTRL_STRIDE2_EN
         ds_row       <= '0;
         ds_col       <= '0;
`endif
      end else begin
         window_valid <= emit;
         if (emit) begin
            out_row  <= orow_q;
            out_col  <= ocol_q;
            pad_mask <= win_mask;
`ifdef CONV3X3_STREAM_CTRL_STRIDE2_EN
            ds_row   <= orow_q[CNT_W-1:1];
            ds_col   <= ocol_q[CNT_W-1:1];
`endif
         end

         // Window centre trails the input by one row and one column.
         if (win_stb) begin
            if (ocol_q == LastIdx) begin
               ocol_q <= '0;
               orow_q <= (orow_q == LastIdx) ? '0 : orow_q + 1'b1;
            end else begin
               ocol_q <= ocol_q + 1'b1;
            end
         end

         if (accept) begin
            if (icol_q == LastIdx) begin
               icol_q <= '0;
               irow_q <= (irow_q == LastIdx) ? '0 : irow_q + 1'b1;
            end else begin
               icol_q <= icol_q + 1'b1;
            end
         end

         if (shift_en && (strobe_q != StrobeMax)) strobe_q <= strobe_q + 1'b1;

         unique case (state_q)
            StIdle: begin
               irow_q   <= '0;
               icol_q   <= '0;
               orow_q   <= '0;
               ocol_q   <= '0;
               flush_q  <= '0;
               strobe_q <= '0;
               if (start) begin
                  state_q <= StRun;
                  busy    <= 1'b1;
               end
            end
            StRun: begin
               if (last_px) state_q <= StFlush;
            end
            StFlush: begin
               flush_q <= flush_q + 1'b1;
               if (flush_q == FlushLast) begin
                  state_q    <= StDone;
                  frame_done <= 1'b1;
               end
            end
            StDone: begin
               state_q    <= StIdle;
               frame_done <= 1'b0;
               busy       <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_conv3x3_stream_ctrl.sv
// Self-checking bench for conv3x3_stream_ctrl at IMG_SIZE=4. The reference
// model derives expected strobes and windows from frame-level counts: accepts
// taken, flush cycles elapsed, and the strobe index of each completed window.
module tb_conv3x3_stream_ctrl;

   localparam int N  = 4;
   localparam int CW = $clog2(N);
`ifdef CONV3X3_STREAM_CTRL_STRIDE2_EN
   localparam int ExpWins = ((N + 1) / 2) * ((N + 1) / 2);
`else
   localparam int ExpWins = N * N;
`endif

   logic          Clk = 1'b0;
   logic          Rst;
   logic          start;
   logic          valid_in;
   logic          in_ready;
   logic          shift_en;
   logic          window_valid;
   logic [CW-1:0] out_row;
   logic [CW-1:0] out_col;
   logic [8:0]    pad_mask;
   logic          busy;
   logic          frame_done;
`ifdef CONV3X3_STREAM_CTRL_STRIDE2_EN
   logic [CW-2:0] ds_row;
   logic [CW-2:0] ds_col;
`endif

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   conv3x3_stream_ctrl #(
      .IMG_SIZE (N)
   ) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .start        (start),
      .valid_in     (valid_in),
      .in_ready     (in_ready),
      .shift_en     (shift_en),
      .window_valid (window_valid),
      .out_row      (out_row),
      .out_col      (out_col),
      .pad_mask     (pad_mask),
      .busy         (busy),
      .frame_done   (frame_done)
`ifdef CONV3X3_STREAM_CTRL_STRIDE2_EN
      ,
      .ds_row       (ds_row),
      .ds_col       (ds_col)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Same-padding rule: taps outside the image on each border.
   function automatic logic [8:0] ref_mask(input int r, input int c);
      logic [8:0] m;
      m = '0;
      for (int k = 0; k < 9; k++) begin
         if ((r + k / 3 - 1) < 0 || (r + k / 3 - 1) > N - 1 ||
             (c + k % 3 - 1) < 0 || (c + k % 3 - 1) > N - 1) m[k] = 1'b1;
      end
      return m;
   endfunction

   function automatic bit emitted(input int r, input int c);
`ifdef CONV3X3_STREAM_CTRL_STRIDE2_EN
      return (r % 2 == 0) && (c % 2 == 0);
`else
      return 1'b1;
`endif
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'(0));
      chk({tag, "_shift_en"}, 32'(shift_en), 32'(0));
      chk({tag, "_window_valid"}, 32'(window_valid), 32'(0));
      chk({tag, "_busy"}, 32'(busy), 32'(0));
      chk({tag, "_frame_done"}, 32'(frame_done), 32'(0));
   endtask

   task automatic check_zero(input string tag);
      check_idle(tag);
      chk({tag, "_out_row"}, 32'(out_row), 32'(0));
      chk({tag, "_out_col"}, 32'(out_col), 32'(0));
      chk({tag, "_pad_mask"}, 32'(pad_mask), 32'(0));
`ifdef CONV3X3_STREAM_CTRL_STRIDE2_EN
      chk({tag, "_ds_row"}, 32'(ds_row), 32'(0));
      chk({tag, "_ds_col"}, 32'(ds_col), 32'(0));
`endif
   endtask

   // vmode: 0 = valid held high, 1 = toggling, 2 = random.
   // rst_at > 0 aborts the frame with Rst after that many accepts.
   // spur = 1 pulses start randomly while the frame is in progress.
   task automatic run_frame(input int vmode, input int rst_at, input bit spur);
      int acc, flush, strobes, wins, idx, exp_r, exp_c;
      bit exp_wv, run, done, exp_sh;
      acc = 0; flush = 0; strobes = 0; wins = 0; exp_r = 0; exp_c = 0;
      exp_wv = 0; done = 0;

      @(posedge Clk); #1;
      start    = 1'b1;
      valid_in = 1'(($urandom % 2));
      @(negedge Clk);
      check_idle("pre_start");
      @(posedge Clk); #1;
      start = 1'b0;

      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         if (vmode == 0)      valid_in = 1'b1;
         else if (vmode == 1) valid_in = (cyc % 2 == 0);
         else                 valid_in = 1'(($urandom % 2));
         start = spur ? ($urandom % 3 == 0) : 1'b0;

         @(negedge Clk);
         run    = (acc < N * N);
         exp_sh = run ? valid_in : (flush < N + 1);
         chk("in_ready", 32'(in_ready), 32'(run));
         chk("shift_en", 32'(shift_en), 32'(exp_sh));
         chk("busy", 32'(busy), 32'(1));
         chk("frame_done", 32'(frame_done), 32'(!run && flush == N + 1));
         chk("window_valid", 32'(window_valid), 32'(exp_wv));
         if (exp_wv && window_valid) begin
            wins++;
            chk("out_row", 32'(out_row), 32'(exp_r));
            chk("out_col", 32'(out_col), 32'(exp_c));
            chk("pad_mask", 32'(pad_mask), 32'(ref_mask(exp_r, exp_c)));
`ifdef CONV3X3_STREAM_CTRL_STRIDE2_EN
            chk("ds_row", 32'(ds_row), 32'(exp_r / 2));
            chk("ds_col", 32'(ds_col), 32'(exp_c / 2));
`endif
            if (exp_r == 0 && exp_c == 0) chk("pad_0_0", 32'(pad_mask), 32'(9'b001001111));
            if (exp_r == 0 && exp_c == 3) chk("pad_0_3", 32'(pad_mask), 32'(9'b100100111));
            if (exp_r == 1 && exp_c == 1) chk("pad_1_1", 32'(pad_mask), 32'(9'b000000000));
            if (exp_r == 3 && exp_c == 3) chk("pad_3_3", 32'(pad_mask), 32'(9'b111100100));
            if (exp_r == 3 && exp_c == 0) chk("pad_3_0", 32'(pad_mask), 32'(9'b111001001));
         end
         if (!run && flush == N + 1) done = 1'b1;

         // Strobe number s (0-based) completes window s-(N+1) in raster order.
         exp_wv = 1'b0;
         if (exp_sh) begin
            if (strobes >= N + 1) begin
               idx    = strobes - (N + 1);
               exp_r  = idx / N;
               exp_c  = idx % N;
               exp_wv = emitted(exp_r, exp_c);
            end
            strobes++;
         end
         if (run && valid_in) acc++;
         else if (!run)       flush++;

         if (rst_at > 0 && acc == rst_at) begin
            Rst = 1'b1;
            @(negedge Clk);
            check_zero("mid_reset");
            @(posedge Clk); #1;
            Rst      = 1'b0;
            start    = 1'b0;
            valid_in = 1'b0;
            @(negedge Clk);
            check_idle("post_reset");
            return;
         end

         if (!done) begin
            @(posedge Clk); #1;
         end
      end

      chk("frame_timeout", 32'(done), 32'(1));
      chk("window_count", 32'(wins), 32'(ExpWins));
      start    = 1'b0;
      valid_in = 1'b0;
   endtask

   initial begin
      // Start together with Rst: Rst wins.
      Rst      = 1'b1;
      start    = 1'b1;
      valid_in = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      start = 1'b0;
      @(negedge Clk);
      check_zero("reset");
      @(posedge Clk); #1;
      Rst = 1'b0;
      @(negedge Clk);
      check_zero("after_reset");

      run_frame(0, 0, 1'b0);   // valid held high
      run_frame(1, 0, 1'b0);   // valid toggling, back-to-back
      run_frame(2, 7, 1'b0);   // abort after 7th accept
      run_frame(2, 0, 1'b1);   // clean frame, spurious start pulses
      run_frame(2, 0, 1'b0);   // back-to-back random stall
      run_frame(0, 0, 1'b1);

      @(posedge Clk); #1;
      @(negedge Clk);
      check_idle("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
